// File: rtl/program_sequencer.sv
// program_sequencer: per-cycle next-fetch-address selection for the Galetron core.
// Sources: increment, conditional relative branch, absolute jump, call/return
// through a circular return-address stack, and a forced context-exchange vector.
// Optional feature macro: PROGRAM_SEQUENCER_RAS_EN builds the return-address stack;
// without it call acts as jump, ret as increment, and the RAS outputs are 0.
module program_sequencer #(
    parameter int ADDR_W       = 12,
    parameter int RESET_VECTOR = 256,
    parameter int CTX_VECTOR   = 1079,
    parameter int RAS_DEPTH    = 4
) (
    input  logic                         clock,
    input  logic                         resetCPU_n,
    input  logic [ADDR_W-1:0]            address,
    input  logic                         zero,
    input  logic                         negative,
    input  logic                         bzero,
    input  logic                         bnegative,
    input  logic                         jump,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         HLT,
    input  logic                         jump_context_exchange,
    input  logic                         clear_flags,
    output logic [ADDR_W-1:0]            programCounter,
    output logic [ADDR_W-1:0]            saved_pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);
    logic [ADDR_W-1:0] pc_q, pc_d, saved_pc_q, saved_pc_d;
    logic [ADDR_W-1:0] pc_inc, branch_add, seq_pc;
    logic              take_branch;

    // Both sums wrap naturally; a two's-complement offset branches backward.
    assign pc_inc      = pc_q + 1'b1;
    assign branch_add  = pc_inc + address;
    assign take_branch = (bzero & zero) | (bnegative & negative);

`ifdef PROGRAM_SEQUENCER_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d, top_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              push, pop, new_ovf, new_unf, ras_upd;

    assign top_inc = top_q + 1'b1;
    // RAS updates are suppressed by halt and by a context exchange.
    assign ras_upd = ~HLT & ~jump_context_exchange;

    // Sequential next-PC (everything below context exchange) plus RAS push/pop intent
    always_comb begin
        seq_pc  = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (ret) begin
            if (cnt_q != '0) begin
                seq_pc = ras_q[top_q];
                pop    = 1'b1;
            end else begin
                new_unf = 1'b1;
            end
        end else if (call) begin
            seq_pc  = address;
            push    = 1'b1;
            new_ovf = (cnt_q == CNT_W'(RAS_DEPTH));
        end else if (jump) begin
            seq_pc = address;
        end else if (take_branch) begin
            seq_pc = branch_add;
        end
    end

    // RAS storage, pointer, count and sticky flags; a new error beats clear_flags
    always_comb begin
        ras_d = ras_q;
        top_d = top_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (!HLT && clear_flags) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ras_upd) begin
            if (pop) begin
                top_d = top_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
            if (push) begin
                // When full, top_inc lands on the oldest entry: circular overwrite.
                ras_d[top_inc] = pc_inc;
                top_d          = top_inc;
                if (!new_ovf) cnt_d = cnt_q + 1'b1;
            end
            if (new_ovf) ovf_d = 1'b1;
            if (new_unf) unf_d = 1'b1;
        end
    end

    // RAS state registers
    always_ff @(posedge clock or negedge resetCPU_n) begin
        if (!resetCPU_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ras_q <= ras_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
`else
    logic unused_clear_flags;
    assign unused_clear_flags = clear_flags;

    // Sequential next-PC without a stack: ret increments, call is a plain jump
    always_comb begin
        seq_pc = pc_inc;
        if (ret) begin
            seq_pc = pc_inc;
        end else if (call || jump) begin
            seq_pc = address;
        end else if (take_branch) begin
            seq_pc = branch_add;
        end
    end

    assign ras_count     = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    // Halt holds; context exchange overrides and records where we would have gone
    always_comb begin
        pc_d       = pc_q;
        saved_pc_d = saved_pc_q;
        if (!HLT) begin
            if (jump_context_exchange) begin
                pc_d       = ADDR_W'(CTX_VECTOR);
                saved_pc_d = seq_pc;
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    // PC and resume-address registers
    always_ff @(posedge clock or negedge resetCPU_n) begin
        if (!resetCPU_n) begin
            pc_q       <= ADDR_W'(RESET_VECTOR);
            saved_pc_q <= ADDR_W'(RESET_VECTOR);
        end else begin
            pc_q       <= pc_d;
            saved_pc_q <= saved_pc_d;
        end
    end

    assign programCounter = pc_q;
    assign saved_pc       = saved_pc_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares against the DUT outputs.
module tb_program_sequencer;
`ifdef PROGRAM_SEQUENCER_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif
    localparam logic [9:0] NONE = 10'd0, Z = 10'd1, N = 10'd2, BZ = 10'd4, BN = 10'd8,
                           J = 10'd16, CA = 10'd32, RT = 10'd64, H = 10'd128,
                           CX = 10'd256, CF = 10'd512;

    logic        clock = 1'b0;
    logic        resetCPU_n = 1'b1;
    logic [11:0] address = '0;
    logic        zero = 0, negative = 0, bzero = 0, bnegative = 0, jump = 0, call = 0, ret = 0;
    logic        HLT = 0, jump_context_exchange = 0, clear_flags = 0;
    logic [11:0] programCounter, saved_pc;
    logic [2:0]  ras_count;
    logic        ras_overflow, ras_underflow;

    program_sequencer dut (
        .clock(clock), .resetCPU_n(resetCPU_n), .address(address), .zero(zero),
        .negative(negative), .bzero(bzero), .bnegative(bnegative), .jump(jump),
        .call(call), .ret(ret), .HLT(HLT), .jump_context_exchange(jump_context_exchange),
        .clear_flags(clear_flags), .programCounter(programCounter), .saved_pc(saved_pc),
        .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       nm;
        logic [11:0] pc;
        logic [11:0] sv;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: one expectation is due at each negedge after it is queued
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if ({programCounter, saved_pc, ras_count, ras_overflow, ras_underflow} !==
                {e.pc, e.sv, e.cnt, e.ovf, e.unf}) begin
                bad++;
                $display("FAIL %s: got pc=%0d saved=%0d cnt=%0d ovf=%0b unf=%0b, need pc=%0d saved=%0d cnt=%0d ovf=%0b unf=%0b",
                         e.nm, programCounter, saved_pc, ras_count, ras_overflow, ras_underflow,
                         e.pc, e.sv, e.cnt, e.ovf, e.unf);
            end
        end
    end

    task automatic expect_out(input string nm, input logic [11:0] pc, input logic [11:0] sv,
                              input logic [2:0] cnt, input logic ovf, input logic unf);
        exp_t e;
        e.nm = nm; e.pc = pc; e.sv = sv; e.cnt = cnt; e.ovf = ovf; e.unf = unf;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of requests and queue the state expected after the next edge
    task automatic cyc(input string nm, input logic [11:0] a, input logic [9:0] c,
                       input logic [11:0] pc, input logic [11:0] sv,
                       input logic [2:0] cnt, input logic ovf, input logic unf);
        address = a;
        {clear_flags, jump_context_exchange, HLT, ret, call, jump,
         bnegative, bzero, negative, zero} = c;
        expect_out(nm, pc, sv, cnt, ovf, unf);
        @(negedge clock); #1;
    endtask

    initial begin
        #1 resetCPU_n = 1'b0;
        @(negedge clock); #1;
        expect_out("reset_values", 12'd256, 12'd256, 3'd0, 1'b0, 1'b0);
        @(negedge clock); #1;
        resetCPU_n = 1'b1;
        cyc("first_inc", 12'd0, NONE, 12'd257, 12'd256, 3'd0, 0, 0);
        cyc("jump300", 12'd300, J, 12'd300, 12'd256, 3'd0, 0, 0);
        cyc("call_before_rst", 12'd500, CA, 12'd500, 12'd256, RAS ? 3'd1 : 3'd0, 0, 0);

        // Asynchronous reset dropped between edges, checked before any further edge
        address = '0;
        {clear_flags, jump_context_exchange, HLT, ret, call, jump,
         bnegative, bzero, negative, zero} = NONE;
        @(posedge clock); #2;
        resetCPU_n = 1'b0;
        expect_out("async_reset", 12'd256, 12'd256, 3'd0, 1'b0, 1'b0);
        @(negedge clock); #1;
        resetCPU_n = 1'b1;
        cyc("inc257", 12'd0, NONE, 12'd257, 12'd256, 3'd0, 0, 0);
        cyc("inc258", 12'd0, NONE, 12'd258, 12'd256, 3'd0, 0, 0);

        // Conditional relative branches
        cyc("jump300b", 12'd300, J, 12'd300, 12'd256, 3'd0, 0, 0);
        cyc("bz_taken_back", 12'hFFE, BZ | Z, 12'd299, 12'd256, 3'd0, 0, 0);
        cyc("jump300c", 12'd300, J, 12'd300, 12'd256, 3'd0, 0, 0);
        cyc("bz_not_taken", 12'hFFE, BZ, 12'd301, 12'd256, 3'd0, 0, 0);
        cyc("jump300d", 12'd300, J, 12'd300, 12'd256, 3'd0, 0, 0);
        cyc("bn_taken", 12'd5, BN | N, 12'd306, 12'd256, 3'd0, 0, 0);

`ifdef PROGRAM_SEQUENCER_RAS_EN
        // Nested call/ret
        cyc("jump300e", 12'd300, J, 12'd300, 12'd256, 3'd0, 0, 0);
        cyc("call500", 12'd500, CA, 12'd500, 12'd256, 3'd1, 0, 0);
        cyc("call700", 12'd700, CA, 12'd700, 12'd256, 3'd2, 0, 0);
        cyc("ret_to501", 12'd0, RT, 12'd501, 12'd256, 3'd1, 0, 0);
        cyc("ret_to301", 12'd0, RT, 12'd301, 12'd256, 3'd0, 0, 0);
        // Overflow: fifth push overwrites the oldest return address (302)
        cyc("call1000", 12'd1000, CA, 12'd1000, 12'd256, 3'd1, 0, 0);
        cyc("call1100", 12'd1100, CA, 12'd1100, 12'd256, 3'd2, 0, 0);
        cyc("call1200", 12'd1200, CA, 12'd1200, 12'd256, 3'd3, 0, 0);
        cyc("call1300", 12'd1300, CA, 12'd1300, 12'd256, 3'd4, 0, 0);
        cyc("call1400_ovf", 12'd1400, CA, 12'd1400, 12'd256, 3'd4, 1, 0);
        cyc("ret1301", 12'd0, RT, 12'd1301, 12'd256, 3'd3, 1, 0);
        cyc("ret1201", 12'd0, RT, 12'd1201, 12'd256, 3'd2, 1, 0);
        cyc("ret1101", 12'd0, RT, 12'd1101, 12'd256, 3'd1, 1, 0);
        cyc("ret1001", 12'd0, RT, 12'd1001, 12'd256, 3'd0, 1, 0);
        cyc("ret_underflow", 12'd0, RT, 12'd1002, 12'd256, 3'd0, 1, 1);
        cyc("clear_flags", 12'd0, CF, 12'd1003, 12'd256, 3'd0, 0, 0);
        cyc("clear_vs_new_unf", 12'd0, RT | CF, 12'd1004, 12'd256, 3'd0, 0, 1);
        cyc("clear_flags2", 12'd0, CF, 12'd1005, 12'd256, 3'd0, 0, 0);
        // ret beats call in the same cycle
        cyc("call500b", 12'd500, CA, 12'd500, 12'd256, 3'd1, 0, 0);
        cyc("ret_over_call", 12'd900, RT | CA, 12'd1006, 12'd256, 3'd0, 0, 0);
`else
        // Without the stack: call jumps, ret increments, count stays 0
        cyc("jump300e", 12'd300, J, 12'd300, 12'd256, 3'd0, 0, 0);
        cyc("call_as_jump", 12'd500, CA, 12'd500, 12'd256, 3'd0, 0, 0);
        cyc("ret_as_inc", 12'd0, RT, 12'd501, 12'd256, 3'd0, 0, 0);
        cyc("ret_over_call", 12'd900, RT | CA, 12'd502, 12'd256, 3'd0, 0, 0);
        cyc("ret_clear", 12'd0, RT | CF, 12'd503, 12'd256, 3'd0, 0, 0);
`endif

        // Context exchange and halt
        cyc("jump400", 12'd400, J, 12'd400, 12'd256, 3'd0, 0, 0);
        cyc("ctx_with_jump", 12'd900, J | CX, 12'd1079, 12'd900, 3'd0, 0, 0);
        cyc("jump400b", 12'd400, J, 12'd400, 12'd900, 3'd0, 0, 0);
        cyc("call600", 12'd600, CA, 12'd600, 12'd900, RAS ? 3'd1 : 3'd0, 0, 0);
        cyc("hlt_ctx_hold", 12'd950, J | CX | H, 12'd600, 12'd900, RAS ? 3'd1 : 3'd0, 0, 0);
        cyc("hlt_ret_hold", 12'd0, RT | H, 12'd600, 12'd900, RAS ? 3'd1 : 3'd0, 0, 0);
        cyc("ctx_with_ret", 12'd0, RT | CX, 12'd1079, RAS ? 12'd401 : 12'd601,
            RAS ? 3'd1 : 3'd0, 0, 0);
        cyc("ret_after_ctx", 12'd0, RT, RAS ? 12'd401 : 12'd1080,
            RAS ? 12'd401 : 12'd601, 3'd0, 0, 0);

        // Address wrap
        cyc("jump4095", 12'd4095, J, 12'd4095, RAS ? 12'd401 : 12'd601, 3'd0, 0, 0);
        cyc("wrap_to0", 12'd0, NONE, 12'd0, RAS ? 12'd401 : 12'd601, 3'd0, 0, 0);
        cyc("branch_fwd", 12'd5, BZ | Z, 12'd6, RAS ? 12'd401 : 12'd601, 3'd0, 0, 0);

        address = '0;
        {clear_flags, jump_context_exchange, HLT, ret, call, jump,
         bnegative, bzero, negative, zero} = NONE;
        @(negedge clock); #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, need completion");
        $fatal(1, "timeout");
    end
endmodule
